ram_scan_reader: RTL and testbench

Read-side responder for the main-memory enable/acknowledge job protocol. When the top-level controller raises `enable`, this block reads a window of words from the 2048×32 main memory and reduces them to a 32-bit modular sum. It then raises `acknowledge` and holds it until the controller drops `enable`. It is the read-back counterpart of the RAM write job: the controller uses it to verify or fingerprint the drawing RAM before handing the memory to the VGA draw job.

---
 rtl/ram_scan_reader.sv | 160 ++++++++++++++++
 tb/tb_ram_scan_reader.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_reader.sv
// Read-side job responder: scans a memory window and reduces it to a 32-bit sum.
// Define RAM_SCAN_COUNT_EN to build the nonzero-word counter behind nonzeroCount.
module ram_scan_reader #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 2,
    parameter int START_ADDR = 0,
    parameter int WORD_COUNT = 2048
) (
    input  logic              CLOCK_50,
    input  logic              resetIn,
    input  logic              enable,
    input  logic [DATA_W-1:0] dataRead,
    output logic [ADDR_W-1:0] address,
    output logic              acknowledge,
    output logic              busy,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W:0]   nonzeroCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(WORD_COUNT - 1);
    localparam logic [2:0]        DLAST = 3'(READ_LAT - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_idx;
    logic [2:0]          r_drain;
    logic [READ_LAT-1:0] r_vld;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_sum;
    logic                r_ack;
    logic                r_busy;

    logic              w_start;
    logic              w_take;
    logic              w_finish;
    logic [DATA_W-1:0] w_acc_next;

    assign w_start    = (r_state == S_IDLE) && enable;
    assign w_take     = r_vld[READ_LAT-1];
    assign w_finish   = (r_state == S_DRAIN) && enable && (r_drain == DLAST);
    assign w_acc_next = r_acc + dataRead;

    // The tag pipe mirrors the memory latency so each returning word is summed once.
    always_ff @(posedge CLOCK_50 or negedge resetIn) begin
        if (!resetIn) begin
            r_state <= S_IDLE;
            r_addr  <= START;
            r_idx   <= '0;
            r_drain <= '0;
            r_vld   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_vld[0] <= (r_state == S_SCAN) && enable;
            for (int k = 1; k < READ_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
            if (w_take) begin
                r_acc <= w_acc_next;
            end
            unique case (r_state)
                S_IDLE: begin
                    r_addr <= START;
                    if (enable) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        r_vld   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_addr  <= START;
                        r_vld   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_idx == LAST) begin
                        r_state <= S_DRAIN;
                        r_drain <= '0;
                        r_addr  <= START;
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_vld   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_drain == DLAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_ack   <= 1'b1;
                        r_sum   <= w_take ? w_acc_next : r_acc;
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                S_DONE: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RAM_SCAN_COUNT_EN
    logic [ADDR_W:0] r_cnt;
    logic [ADDR_W:0] r_nz;
    logic            w_nz;
    logic [ADDR_W:0] w_cnt_next;

    assign w_nz       = w_take && (dataRead != '0);
    assign w_cnt_next = r_cnt + {{ADDR_W{1'b0}}, w_nz};

    always_ff @(posedge CLOCK_50 or negedge resetIn) begin
        if (!resetIn) begin
            r_cnt <= '0;
            r_nz  <= '0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_take) begin
                r_cnt <= w_cnt_next;
            end
            if (w_finish) begin
                r_nz <= w_cnt_next;
            end
        end
    end

    assign nonzeroCount = r_nz;
`else
    assign nonzeroCount = '0;
`endif

    assign address     = r_addr;
    assign acknowledge = r_ack;
    assign busy        = r_busy;
    assign checksum    = r_sum;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader: main instance (full 2048-word scan) plus a
// small wrap-around instance, both fed by latency-2 memory models.
module tb_ram_scan_reader;

    localparam int W = 2048;
    localparam int L = 2;

    logic        clk;
    logic        resetIn;
    logic        enable;
    logic [31:0] dataRead;
    logic [10:0] address;
    logic        acknowledge;
    logic        busy;
    logic [31:0] checksum;
    logic [11:0] nonzeroCount;

    logic        en2;
    logic [31:0] data2;
    logic [10:0] addr2;
    logic        ack2;
    logic        busy2;
    logic [31:0] sum2;
    logic [11:0] nz2;

    int checks;
    int failures;

    logic [31:0] mem  [W];
    logic [31:0] mem2 [W];
    logic [31:0] rq0, rq1, rw0, rw1;

    ram_scan_reader u_dut (
        .CLOCK_50     (clk),
        .resetIn      (resetIn),
        .enable       (enable),
        .dataRead     (dataRead),
        .address      (address),
        .acknowledge  (acknowledge),
        .busy         (busy),
        .checksum     (checksum),
        .nonzeroCount (nonzeroCount)
    );

    ram_scan_reader #(
        .START_ADDR (2046),
        .WORD_COUNT (4)
    ) u_wrap (
        .CLOCK_50     (clk),
        .resetIn      (resetIn),
        .enable       (en2),
        .dataRead     (data2),
        .address      (addr2),
        .acknowledge  (ack2),
        .busy         (busy2),
        .checksum     (sum2),
        .nonzeroCount (nz2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        rq0 <= mem[address];
        rq1 <= rq0;
        rw0 <= mem2[addr2];
        rw1 <= rw0;
    end
    assign dataRead = rq1;
    assign data2    = rw1;

    logic [31:0] exp_sum;
    int          exp_nz;

    task automatic model_main();
        exp_sum = 32'd0;
        exp_nz  = 0;
        for (int i = 0; i < W; i++) begin
            exp_sum = exp_sum + mem[i % W];
            if (mem[i % W] != 32'd0) exp_nz++;
        end
`ifndef RAM_SCAN_COUNT_EN
        exp_nz = 0;
`endif
    endtask

    task automatic fill_random();
        for (int a = 0; a < W; a++) begin
            mem[a] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
        end
    endtask

    task automatic run_scan(output int ack_cyc, output int busy_cyc,
                            output int addr_err);
        enable   = 1'b1;
        ack_cyc  = -1;
        busy_cyc = 0;
        addr_err = 0;
        for (int n = 1; n <= W + L + 20; n++) begin
            @(negedge clk);
            if (n <= W && address !== 11'(n - 1)) addr_err++;
            if (busy === 1'b1) busy_cyc++;
            if (acknowledge === 1'b1) begin
                ack_cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetIn = 1'b0;
        enable  = 1'b0;
        en2     = 1'b0;
        repeat (3) @(negedge clk);
        resetIn = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (acknowledge !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack got=%b want=0", acknowledge);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        checks++;
        if (checksum !== 32'd0) begin
            failures++;
            $display("FAIL reset_sum got=%h want=0", checksum);
        end
        checks++;
        if (address !== 11'd0) begin
            failures++;
            $display("FAIL reset_addr got=%0d want=0", address);
        end
        checks++;
        if (nonzeroCount !== 12'd0) begin
            failures++;
            $display("FAIL reset_nz got=%0d want=0", nonzeroCount);
        end
        checks++;
        if (addr2 !== 11'd2046) begin
            failures++;
            $display("FAIL reset_addr_wrap got=%0d want=2046", addr2);
        end
    endtask

    task automatic test_wrap();
        int exp_addr [4];
        int ack_cyc;
        exp_addr[0] = 2046;
        exp_addr[1] = 2047;
        exp_addr[2] = 0;
        exp_addr[3] = 1;
        for (int a = 0; a < W; a++) mem2[a] = $urandom();
        mem2[2046] = 32'd1;
        mem2[2047] = 32'd2;
        mem2[0]    = 32'd3;
        mem2[1]    = 32'd4;
        ack_cyc = -1;
        en2 = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n <= 4) begin
                checks++;
                if (addr2 !== 11'(exp_addr[n-1])) begin
                    failures++;
                    $display("FAIL wrap_addr%0d got=%0d want=%0d",
                             n - 1, addr2, exp_addr[n-1]);
                end
            end
            if (ack2 === 1'b1) begin
                ack_cyc = n;
                break;
            end
        end
        checks++;
        if (ack_cyc != 4 + L + 1) begin
            failures++;
            $display("FAIL wrap_ack_cycle got=%0d want=%0d", ack_cyc, 4 + L + 1);
        end
        checks++;
        if (sum2 !== 32'd10) begin
            failures++;
            $display("FAIL wrap_sum got=%0d want=10", sum2);
        end
        checks++;
`ifdef RAM_SCAN_COUNT_EN
        if (nz2 !== 12'd4) begin
            failures++;
            $display("FAIL wrap_nz got=%0d want=4", nz2);
        end
`else
        if (nz2 !== 12'd0) begin
            failures++;
            $display("FAIL wrap_nz got=%0d want=0", nz2);
        end
`endif
        en2 = 1'b0;
        @(negedge clk);
        checks++;
        if (ack2 !== 1'b0) begin
            failures++;
            $display("FAIL wrap_ack_drop got=%b want=0", ack2);
        end
    endtask

    task automatic test_full_ramp();
        int ack_cyc, busy_cyc, addr_err;
        for (int a = 0; a < W; a++) mem[a] = 32'(a);
        model_main();
        run_scan(ack_cyc, busy_cyc, addr_err);
        checks++;
        if (ack_cyc != W + L + 1) begin
            failures++;
            $display("FAIL ramp_ack_cycle got=%0d want=%0d", ack_cyc, W + L + 1);
        end
        checks++;
        if (busy_cyc != W + L) begin
            failures++;
            $display("FAIL ramp_busy_cycles got=%0d want=%0d", busy_cyc, W + L);
        end
        checks++;
        if (addr_err != 0) begin
            failures++;
            $display("FAIL ramp_addr_seq bad_cycles=%0d want=0", addr_err);
        end
        checks++;
        if (checksum !== 32'h001F_FC00 || checksum !== exp_sum) begin
            failures++;
            $display("FAIL ramp_sum got=%h want=%h", checksum, exp_sum);
        end
        checks++;
        if (nonzeroCount !== 12'(exp_nz)) begin
            failures++;
            $display("FAIL ramp_nz got=%0d want=%0d", nonzeroCount, exp_nz);
        end
    endtask

    task automatic test_held();
        int bad;
        int ack_cyc, busy_cyc, addr_err;
        logic [31:0] prev;
        prev = checksum;
        bad  = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (acknowledge !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL held_ack bad_cycles=%0d want=0", bad);
        end
        checks++;
        if (checksum !== prev) begin
            failures++;
            $display("FAIL held_sum got=%h want=%h", checksum, prev);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (acknowledge !== 1'b0) begin
            failures++;
            $display("FAIL held_ack_drop got=%b want=0", acknowledge);
        end
        fill_random();
        model_main();
        run_scan(ack_cyc, busy_cyc, addr_err);
        checks++;
        if (ack_cyc != W + L + 1) begin
            failures++;
            $display("FAIL rescan_ack_cycle got=%0d want=%0d", ack_cyc, W + L + 1);
        end
        checks++;
        if (checksum !== exp_sum) begin
            failures++;
            $display("FAIL rescan_sum got=%h want=%h", checksum, exp_sum);
        end
        checks++;
        if (nonzeroCount !== 12'(exp_nz)) begin
            failures++;
            $display("FAIL rescan_nz got=%0d want=%0d", nonzeroCount, exp_nz);
        end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int ack_cyc, busy_cyc, addr_err, acks;
        int prior_nz;
        for (int a = 0; a < W; a++) mem[a] = 32'd0;
        mem[0] = 32'h1234;
        model_main();
        prior_nz = exp_nz;
        run_scan(ack_cyc, busy_cyc, addr_err);
        checks++;
        if (checksum !== 32'h1234) begin
            failures++;
            $display("FAIL abort_prior_sum got=%h want=00001234", checksum);
        end
        enable = 1'b0;
        @(negedge clk);
        for (int a = 0; a < W; a++) mem[a] = $urandom() | 32'd1;
        enable = 1'b1;
        for (int n = 1; n <= 101; n++) @(negedge clk);
        checks++;
        if (address !== 11'd100) begin
            failures++;
            $display("FAIL abort_addr100 got=%0d want=100", address);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || address !== 11'd0) begin
            failures++;
            $display("FAIL abort_idle busy=%b addr=%0d want busy=0 addr=0",
                     busy, address);
        end
        acks = 0;
        for (int n = 0; n < W + 20; n++) begin
            @(negedge clk);
            if (acknowledge === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL abort_no_ack got=%0d want=0", acks);
        end
        checks++;
        if (checksum !== 32'h1234) begin
            failures++;
            $display("FAIL abort_sum got=%h want=00001234", checksum);
        end
        checks++;
        if (nonzeroCount !== 12'(prior_nz)) begin
            failures++;
            $display("FAIL abort_nz got=%0d want=%0d", nonzeroCount, prior_nz);
        end
    endtask

    task automatic test_reset_drain();
        int ack_cyc, busy_cyc, addr_err;
        fill_random();
        model_main();
        enable = 1'b1;
        for (int n = 1; n <= W + 1; n++) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || acknowledge !== 1'b0) begin
            failures++;
            $display("FAIL drain_state busy=%b ack=%b want busy=1 ack=0",
                     busy, acknowledge);
        end
        resetIn = 1'b0;
        #1;
        checks++;
        if (acknowledge !== 1'b0 || busy !== 1'b0 || checksum !== 32'd0 ||
            nonzeroCount !== 12'd0 || address !== 11'd0) begin
            failures++;
            $display("FAIL drain_reset ack=%b busy=%b sum=%h nz=%0d addr=%0d want all 0",
                     acknowledge, busy, checksum, nonzeroCount, address);
        end
        enable = 1'b0;
        @(negedge clk);
        resetIn = 1'b1;
        @(negedge clk);
        run_scan(ack_cyc, busy_cyc, addr_err);
        checks++;
        if (ack_cyc != W + L + 1 || busy_cyc != W + L || addr_err != 0) begin
            failures++;
            $display("FAIL post_reset_job ack=%0d busy=%0d addr_err=%0d want %0d %0d 0",
                     ack_cyc, busy_cyc, addr_err, W + L + 1, W + L);
        end
        checks++;
        if (checksum !== exp_sum) begin
            failures++;
            $display("FAIL post_reset_sum got=%h want=%h", checksum, exp_sum);
        end
        checks++;
        if (nonzeroCount !== 12'(exp_nz)) begin
            failures++;
            $display("FAIL post_reset_nz got=%0d want=%0d", nonzeroCount, exp_nz);
        end
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random_scan();
        int ack_cyc, busy_cyc, addr_err;
        for (int a = 0; a < W; a++) begin
            mem[a] = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom();
        end
        model_main();
        run_scan(ack_cyc, busy_cyc, addr_err);
        checks++;
        if (ack_cyc != W + L + 1) begin
            failures++;
            $display("FAIL rand_ack_cycle got=%0d want=%0d", ack_cyc, W + L + 1);
        end
        checks++;
        if (checksum !== exp_sum) begin
            failures++;
            $display("FAIL rand_sum got=%h want=%h", checksum, exp_sum);
        end
        checks++;
        if (nonzeroCount !== 12'(exp_nz)) begin
            failures++;
            $display("FAIL rand_nz got=%0d want=%0d", nonzeroCount, exp_nz);
        end
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetIn  = 1'b0;
        enable   = 1'b0;
        en2      = 1'b0;
        for (int a = 0; a < W; a++) begin
            mem[a]  = 32'd0;
            mem2[a] = 32'd0;
        end
        @(negedge clk);
        test_reset();
        test_wrap();
        test_full_ramp();
        test_held();
        test_abort();
        test_reset_drain();
        test_random_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
